// File: rtl/jk_pkg.sv
// Shared definitions for the JK latch command sequencer: command encodings,
// sequencer states and the shadow-Q update rule.
package jk_pkg;

    localparam int CMD_W = 2;

    localparam logic [CMD_W-1:0] CMD_HOLD = 2'b00;
    localparam logic [CMD_W-1:0] CMD_CLR  = 2'b01;
    localparam logic [CMD_W-1:0] CMD_SET  = 2'b10;
    localparam logic [CMD_W-1:0] CMD_TOG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        APPLY,
        HOLD,
        CHECK
    } jk_state_e;

    // Latch Q after one transparent window driven with cmd = {j,k}.
    function automatic logic next_q(input logic q, input logic [CMD_W-1:0] cmd);
        logic q_n;
        case (cmd)
            CMD_CLR: q_n = 1'b0;
            CMD_SET: q_n = 1'b1;
            CMD_TOG: q_n = ~q;
            default: q_n = q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small command FIFO: power-of-two depth, naturally wrapping pointers,
// head entry visible combinationally so the consumer can latch it on pop.
module jk_cmd_fifo
    import jk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [CMD_W-1:0]         din_i,
    input  logic                     pop_i,
    output logic [CMD_W-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] FULL_COUNT = AW1'(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Overflow / underflow requests are ignored rather than corrupting state.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + AW1'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - AW1'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives a level-sensitive JK latch: each queued command is played out as
// setup / one-cycle enable / hold / check, while a shadow Q tracks the latch.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    // A command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on FIFO occupancy, never on cmd_valid.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CMD_W-1:0] cmd,
    output logic             j,
    output logic             k,
    output logic             le_n,
    input  logic             q_fb,
    output logic             q_exp,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output jk_state_e        dbg_state_o
);

    jk_state_e              state_q, state_d;
    logic [CMD_W-1:0]       cur_cmd_q, cur_cmd_d;
    logic                   j_q, j_d, k_q, k_d, le_n_q, le_n_d;
    logic                   q_exp_q, q_exp_d, done_q, done_d, err_q, err_d;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]       fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);

    jk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (cmd),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        cur_cmd_d = cur_cmd_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = SETUP;
                    fifo_pop = 1'b1;
                end
            end
            SETUP: state_d = APPLY;
            APPLY: state_d = HOLD;
            HOLD:  state_d = CHECK;
            CHECK: begin
                if (!fifo_empty) begin
                    state_d  = SETUP;
                    fifo_pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fifo_pop) begin
            cur_cmd_d = fifo_head;
        end

        // Outputs are registered from the next state, so j/k settle a full
        // cycle before le_n drops and stay put until after it rises.
        j_d    = 1'b0;
        k_d    = 1'b0;
        if (state_d inside {SETUP, APPLY, HOLD}) begin
            j_d = cur_cmd_d[1];
            k_d = cur_cmd_d[0];
        end
        le_n_d = (state_d != APPLY);
        done_d = (state_d == CHECK);

        q_exp_d = q_exp_q;
        if (state_q == APPLY) begin
            q_exp_d = next_q(q_exp_q, cur_cmd_q);
        end

        // A mismatch outranks a simultaneous clear so no error is lost.
        err_d = err_q;
        if (state_q == CHECK && q_fb != q_exp_q) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_cmd_q <= CMD_HOLD;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            le_n_q    <= 1'b1;
            q_exp_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_cmd_q <= cur_cmd_d;
            j_q       <= j_d;
            k_q       <= k_d;
            le_n_q    <= le_n_d;
            q_exp_q   <= q_exp_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign j           = j_q;
    assign k           = k_q;
    assign le_n        = le_n_q;
    assign q_exp       = q_exp_q;
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer with an attached JK latch model,
// an expected-Q scoreboard and an independent JK characteristic-equation model.
module tb_jk_cmd_sequencer;
    import jk_pkg::*;

    localparam int DEPTH = 4;

    logic       clk, rst, cmd_valid, cmd_ready, j, k, le_n, q_fb;
    logic       q_exp, busy, done, err, err_clr;
    logic [1:0] cmd;
    jk_state_e  dbg_state;

    logic       latch_q;
    logic       force_q0;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    logic [0:0] exp_q[$];
    logic [1:0] apply_q[$];
    logic       model_q     = 1'b0;
    logic       err_model   = 1'b0;
    logic       prev_le_low = 1'b0;
    bit         burst_mode  = 1'b0;
    int         last_done   = -1;
    int         le_pulses   = 0;
    int         done_pulses = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .j           (j),
        .k           (k),
        .le_n        (le_n),
        .q_fb        (q_fb),
        .q_exp       (q_exp),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_clr     (err_clr),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // JK latch model, transparent while le_n is low, reset alongside the DUT
    always @(posedge clk) begin
        if (rst) latch_q <= 1'b0;
        else if (!le_n) latch_q <= (j & ~latch_q) | (~k & latch_q);
    end
    assign q_fb = force_q0 ? 1'b0 : latch_q;

    function automatic logic jk_rule(input logic q, input logic [1:0] c);
        return (c[1] & ~q) | (~c[0] & q);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic send_cmd(input logic [1:0] c, input bit keep_valid, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd = c;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                model_q = jk_rule(model_q, c);
                exp_q.push_back(model_q);
                apply_q.push_back(c);
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!keep_valid) cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        chk("drain_busy", busy, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        apply_q.delete();
        model_q = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_j"}, j, 0);
        chk({tag, "_k"}, k, 0);
        chk({tag, "_le_n"}, le_n, 1);
        chk({tag, "_q_exp"}, q_exp, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, dbg_state, IDLE);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic       e;
        logic       mism;
        logic [1:0] a;
        mism = 1'b0;
        chk("err_track", err, err_model);
        if (done === 1'b1) begin
            done_pulses++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("q_exp_at_done", q_exp, e);
                chk("jk_zero_at_done", {j, k}, 0);
                mism = (q_fb !== e);
            end
            if (burst_mode && last_done >= 0) chk("done_spacing", cyc - last_done, 4);
            last_done = cyc;
        end
        if (le_n === 1'b0) begin
            le_pulses++;
            chk("le_n_single_cycle", prev_le_low, 0);
            if (apply_q.size() == 0) begin
                chk("spurious_le_n", 1, 0);
            end else begin
                a = apply_q.pop_front();
                chk("jk_at_apply", {j, k}, a);
            end
        end
        prev_le_low = (le_n === 1'b0);
        if (rst) err_model = 1'b0;
        else if (mism) err_model = 1'b1;
        else if (err_clr) err_model = 1'b0;
    end

    initial begin : stimulus
        bit ok;
        int d0, l0, gap;
        logic [1:0] c;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'b00;
        err_clr = 1'b0;
        force_q0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        // single SET, cycle-accurate
        send_cmd(CMD_SET, 1'b0, ok);
        @(posedge clk); #1;
        chk("e1_state", dbg_state, SETUP);
        chk("e1_jk", {j, k}, 2'b10);
        chk("e1_le_n", le_n, 1);
        @(posedge clk); #1;
        chk("e2_state", dbg_state, APPLY);
        chk("e2_jk", {j, k}, 2'b10);
        chk("e2_le_n", le_n, 0);
        @(posedge clk); #1;
        chk("e3_le_n", le_n, 1);
        chk("e3_jk", {j, k}, 2'b10);
        chk("e3_q_exp", q_exp, 1);
        @(posedge clk); #1;
        chk("e4_done", done, 1);
        chk("e4_jk", {j, k}, 2'b00);
        @(posedge clk); #1;
        chk("e5_done", done, 0);
        chk("e5_err", err, 0);
        chk("e5_busy", busy, 0);

        // burst of five toggles with cmd_valid held
        burst_mode = 1'b1;
        last_done = -1;
        apply_reset();
        check_reset_values("reset2");
        d0 = done_pulses;
        for (int i = 0; i < 5; i++) send_cmd(CMD_TOG, 1'b1, ok);
        chk("burst_full_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_idle();
        burst_mode = 1'b0;
        chk("burst_done_count", done_pulses - d0, 5);
        chk("burst_q_exp", q_exp, 1);
        chk("burst_err", err, 0);

        // mismatch, then clear colliding with a second mismatch
        force_q0 = 1'b1;
        send_cmd(CMD_SET, 1'b0, ok);
        wait_idle();
        chk("mismatch_err", err, 1);
        send_cmd(CMD_SET, 1'b0, ok);
        repeat (4) @(posedge clk);
        #1;
        chk("collide_done", done, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("collide_err_stays", err, 1);
        force_q0 = 1'b0;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_cleared", err, 0);

        // SET, HOLD, CLR, HOLD back-to-back
        l0 = le_pulses;
        send_cmd(CMD_SET, 1'b1, ok);
        send_cmd(CMD_HOLD, 1'b1, ok);
        send_cmd(CMD_CLR, 1'b1, ok);
        send_cmd(CMD_HOLD, 1'b1, ok);
        cmd_valid = 1'b0;
        wait_idle();
        chk("seq_le_pulses", le_pulses - l0, 4);
        chk("seq_q_exp", q_exp, 0);
        chk("seq_err", err, 0);

        // reset during APPLY of a queued stream
        send_cmd(CMD_TOG, 1'b1, ok);
        send_cmd(CMD_SET, 1'b1, ok);
        send_cmd(CMD_TOG, 1'b1, ok);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (le_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("found_apply", ok, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        apply_q.delete();
        model_q = 1'b0;
        check_reset_values("mid_reset");
        d0 = done_pulses;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_pulses - d0, 0);

        // randomized stream with occasional feedback faults and clears
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            force_q0 = ($urandom_range(0, 7) == 0);
            send_cmd(c, 1'b0, ok);
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                err_clr = ($urandom_range(0, 9) == 0);
                @(posedge clk);
                #1;
            end
            err_clr = 1'b0;
        end
        force_q0 = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("apply_q_drained", apply_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Upstream driver for the team's level-sensitive JK storage latch (J, K, active-low enable, synchronous reset). Accepts hold/clear/set/toggle commands over a valid/ready interface, buffers them in a small FIFO, and plays each one out as a glitch-free setup / single-cycle-enable / hold sequence. It keeps a shadow model of the latch output and flags any mismatch with the fed-back Q. The single-cycle enable window keeps a toggle from oscillating while the latch is transparent.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; high when count < DEPTH
- cmd  in  2  {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
- j  out  1  J drive to latch
- k  out  1  K drive to latch
- le_n  out  1  latch enable, active-low (0 = transparent)
- q_fb  in  1  latch Q fed back
- q_exp  out  1  shadow (expected) Q
- busy  out  1  FSM not IDLE or FIFO non-empty
- done  out  1  one-cycle pulse, command completed
- err  out  1  sticky Q mismatch
- err_clr  in  1  clears err

## Operation
- Push on edge with cmd_valid && cmd_ready. Pop only on FSM entry to SETUP.
- Push and pop on the same edge: count unchanged. When full, cmd_ready=0 and no push.
- FSM states: IDLE, SETUP, APPLY, HOLD, CHECK.
- IDLE → SETUP when the FIFO is non-empty. This transition pops the head into cur_cmd and drives j/k from it.
- SETUP: j,k = cur_cmd, le_n=1. Next state APPLY.
- APPLY: j,k = cur_cmd, le_n=0 for exactly one cycle. Next state HOLD. On the edge leaving APPLY, q_exp updates: 00 → unchanged, 01 → 0, 10 → 1, 11 → ~q_exp.
- HOLD: j,k = cur_cmd, le_n=1. Next state CHECK.
- CHECK: j=k=0, le_n=1, done=1.
  - On the edge leaving CHECK, err is set if q_fb != q_exp.
  - Next state SETUP (with pop) if the FIFO is non-empty, else IDLE.
- A hold command (00) still runs the full sequence.
- err_clr clears err. If err_clr and a mismatch occur on the same edge, set wins.
- All outputs registered except cmd_ready and busy, which are decoded from count/state.

## Timing
- Reset values: j=0, k=0, le_n=1, q_exp=0, done=0, err=0, FIFO empty (cmd_ready=1), busy=0, FSM IDLE.
- rst drives the downstream latch reset in parallel, so q_exp=0 matches it.
- Latency when idle and empty: command accepted at edge E0, SETUP from E1, APPLY E2, HOLD E3, CHECK E4, done high in cycle E4..E5, err updated at E5.
- Throughput: one command per 4 cycles back-to-back, with no IDLE cycle between commands.
- j/k never change while le_n=0. le_n is never low for two consecutive cycles.
- Reset mid-operation has full priority: FIFO flushed, in-flight command dropped, all outputs go to reset values at that edge.
- Pointer wrap-around: log2(DEPTH) pointers wrap naturally. count is log2(DEPTH)+1 bits.

## Structure
- Package jk_pkg holds:
  - cmd encoding constants CMD_HOLD/CMD_CLR/CMD_SET/CMD_TOG;
  - the state enum (IDLE, SETUP, APPLY, HOLD, CHECK);
  - a function next_q(q, cmd) for the shadow update, reusable by the bench scoreboard.
- Sub-module jk_cmd_fifo:
  - parameter DEPTH, width 2, synchronous rst;
  - push/pop/full/empty/count, with the head visible combinationally.
- Target size: about 200 lines of RTL in total.

## Test plan
- Reset then a single SET:
  - le_n=0 only at E2; j=1, k=0 from E1 to E4;
  - q_exp=1 after E3; done pulse at E4; err=0 with the latch model attached.
- Burst TOG×5 with cmd_valid held, DEPTH=4:
  - cmd_ready drops when full;
  - done pulses spaced exactly 4 cycles apart;
  - final q_exp=1 (starting from 0), err=0.
- Mismatch: force q_fb=0 during a SET sequence → err=1 after CHECK. Assert err_clr in the same cycle as the next mismatch → err stays 1.
- Reset asserted during APPLY of a queued stream:
  - next cycle j=k=0, le_n=1, q_exp=0, FIFO empty, busy=0;
  - no further done pulses.
- Sequence SET, HOLD, CLR, HOLD:
  - q_exp goes 1, 1, 0, 0;
  - le_n is pulsed once per command, including HOLD;
  - j=k=0 throughout both HOLD commands.
